// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch core: FSM state enum, BCD digit type and
// the two-digit BCD increment helper used by both run and adjust paths.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSE  = 2'd2,
        ADJUST = 2'd3
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t BCD_MAX      = 4'd9;

    typedef struct packed {
        logic wrap;
        bcd_t tens;
        bcd_t ones;
    } bcd_pair_t;

    // Increment a tens/ones pair; at (tens_max, ones_max) it rolls to 00 and flags wrap.
    function automatic bcd_pair_t bcd_pair_inc(input bcd_t tens, input bcd_t ones,
                                               input bcd_t tens_max, input bcd_t ones_max);
        bcd_pair_t r;
        r.wrap = 1'b0;
        r.tens = tens;
        r.ones = ones;
        if ((tens == tens_max) && (ones == ones_max)) begin
            r.wrap = 1'b1;
            r.tens = 4'd0;
            r.ones = 4'd0;
        end else if (ones >= BCD_MAX) begin
            r.tens = tens + 4'd1;
            r.ones = 4'd0;
        end else begin
            r.ones = ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with a rising-edge pulse output. An input already
// high when reset releases does not produce a pulse until it has been seen low.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic pulse
);

    localparam int CW = $clog2(STAGES + 1);

    logic [STAGES-1:0] sync_q;
    logic [CW-1:0]     fill_q;
    logic              low_seen_q;
    logic              valid;

    // The chain holds reset zeros, not real samples, until it has filled.
    assign valid = (fill_q == '0);
    assign level = sync_q[STAGES-1];
    assign pulse = level & low_seen_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            fill_q     <= CW'(STAGES);
            low_seen_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            if (!valid) begin
                fill_q <= fill_q - CW'(1);
            end else begin
                low_seen_q <= ~level;
            end
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: synchronizes sec_clk and buttons, runs the IDLE/RUN/
// PAUSE(/ADJUST) FSM and keeps four BCD digits. ADJUST is built only when
// STOPWATCH_ADJUST_EN is defined.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MIN     = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_clk,
    input  logic       adj_clk,
    input  logic       pause_btn,
    input  logic       reset_btn,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       adjusting
);

    localparam bcd_t MIN_TENS_MAX = bcd_t'(MAX_MIN / 10);
    localparam bcd_t MIN_ONES_MAX = bcd_t'(MAX_MIN % 10);

    logic sec_tick, pause_pe, reset_lvl;
    logic sec_lvl_unused, pause_lvl_unused, reset_pe_unused;
    logic adj_lvl, sel_lvl, adj_tick;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sec (
        .clk(clk), .rst_n(rst), .d(sec_clk), .level(sec_lvl_unused), .pulse(sec_tick)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_pause (
        .clk(clk), .rst_n(rst), .d(pause_btn), .level(pause_lvl_unused), .pulse(pause_pe)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_reset (
        .clk(clk), .rst_n(rst), .d(reset_btn), .level(reset_lvl), .pulse(reset_pe_unused)
    );

`ifdef STOPWATCH_ADJUST_EN
    logic adj_clk_lvl_unused, adj_pe_unused, sel_pe_unused;

    sync_edge #(.STAGES(SYNC_STAGES)) u_adj_clk (
        .clk(clk), .rst_n(rst), .d(adj_clk), .level(adj_clk_lvl_unused), .pulse(adj_tick)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_adj (
        .clk(clk), .rst_n(rst), .d(adj), .level(adj_lvl), .pulse(adj_pe_unused)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sel (
        .clk(clk), .rst_n(rst), .d(sel), .level(sel_lvl), .pulse(sel_pe_unused)
    );
`else
    logic adj_ports_unused;
    assign adj_ports_unused = ^{adj, sel, adj_clk};
    assign adj_lvl  = 1'b0;
    assign sel_lvl  = 1'b0;
    assign adj_tick = 1'b0;
`endif

    sw_state_t state_q, state_d;
    bcd_t      min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
    bcd_t      min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
    bcd_pair_t sec_inc, min_inc;
    logic      running_q, adjusting_q;
    logic      min_wrap_unused;

    // Minute rollover needs no action: the helper already returns 00.
    assign min_wrap_unused = min_inc.wrap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            min_tens_q  <= '0;
            min_ones_q  <= '0;
            sec_tens_q  <= '0;
            sec_ones_q  <= '0;
            running_q   <= 1'b0;
            adjusting_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_tens_q  <= min_tens_d;
            min_ones_q  <= min_ones_d;
            sec_tens_q  <= sec_tens_d;
            sec_ones_q  <= sec_ones_d;
            running_q   <= (state_d == RUN);
            adjusting_q <= (state_d == ADJUST);
        end
    end

    always_comb begin
        state_d    = state_q;
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        sec_inc    = bcd_pair_inc(sec_tens_q, sec_ones_q, SEC_TENS_MAX, BCD_MAX);
        min_inc    = bcd_pair_inc(min_tens_q, min_ones_q, MIN_TENS_MAX, MIN_ONES_MAX);

        if (reset_lvl) begin
            state_d    = IDLE;
            min_tens_d = '0;
            min_ones_d = '0;
            sec_tens_d = '0;
            sec_ones_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pause_pe) begin
                        state_d = RUN;
                    end else if (adj_lvl) begin
                        state_d = ADJUST;
                    end
                end
                RUN: begin
                    // A coincident pause still lets this tick land first.
                    if (sec_tick) begin
                        sec_tens_d = sec_inc.tens;
                        sec_ones_d = sec_inc.ones;
                        if (sec_inc.wrap) begin
                            min_tens_d = min_inc.tens;
                            min_ones_d = min_inc.ones;
                        end
                    end
                    if (pause_pe) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (pause_pe) begin
                        state_d = RUN;
                    end else if (adj_lvl) begin
                        state_d = ADJUST;
                    end
                end
                ADJUST: begin
                    if (!adj_lvl) begin
                        state_d = PAUSE;
                    end else if (adj_tick) begin
                        if (sel_lvl) begin
                            min_tens_d = min_inc.tens;
                            min_ones_d = min_inc.ones;
                        end else begin
                            sec_tens_d = sec_inc.tens;
                            sec_ones_d = sec_inc.ones;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign min_tens = min_tens_q;
    assign min_ones = min_ones_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;
    assign running  = running_q;

`ifdef STOPWATCH_ADJUST_EN
    assign adjusting = adjusting_q;
`else
    logic adjusting_q_unused;
    assign adjusting_q_unused = adjusting_q;
    assign adjusting = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: a vector table for the main counting
// and pause/clear behaviour, plus hand sequences for latency and corner cases.
module tb_stopwatch_counter;

    localparam int SYNC_STAGES = 2;
    localparam int HOLD        = SYNC_STAGES + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sec_clk = 1'b0;
    logic       adj_clk = 1'b0;
    logic       pause_btn = 1'b0;
    logic       reset_btn = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, adjusting;

    int checks = 0;
    int errors = 0;

    stopwatch_counter #(.SYNC_STAGES(SYNC_STAGES), .MAX_MIN(59)) dut (
        .clk(clk), .rst(rst), .sec_clk(sec_clk), .adj_clk(adj_clk),
        .pause_btn(pause_btn), .reset_btn(reset_btn), .adj(adj), .sel(sel),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .adjusting(adjusting)
    );

    always #5 clk = ~clk;

    typedef enum int {ACT_SEC, ACT_PAUSE, ACT_CLEAR} act_t;
    typedef struct {
        act_t        act;
        int          n;
        logic [15:0] exp_time;
        logic        exp_run;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [15:0] mmss();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_sec(input int n);
        for (int i = 0; i < n; i++) begin
            sec_clk = 1'b1;
            cycles(HOLD);
            sec_clk = 1'b0;
            cycles(HOLD);
        end
    endtask

    task automatic press_pause();
        pause_btn = 1'b1;
        cycles(HOLD);
        pause_btn = 1'b0;
        cycles(HOLD);
    endtask

    task automatic press_clear();
        reset_btn = 1'b1;
        cycles(HOLD);
        reset_btn = 1'b0;
        cycles(HOLD);
    endtask

    initial begin
        vecs[0] = '{ACT_PAUSE, 1,  16'h0000, 1'b1};
        vecs[1] = '{ACT_SEC,   61, 16'h0101, 1'b1};
        vecs[2] = '{ACT_PAUSE, 1,  16'h0101, 1'b0};
        vecs[3] = '{ACT_SEC,   5,  16'h0101, 1'b0};
        vecs[4] = '{ACT_PAUSE, 1,  16'h0101, 1'b1};
        vecs[5] = '{ACT_SEC,   8,  16'h0109, 1'b1};
        vecs[6] = '{ACT_CLEAR, 1,  16'h0000, 1'b0};
        vecs[7] = '{ACT_SEC,   3,  16'h0000, 1'b0};
        vecs[8] = '{ACT_PAUSE, 1,  16'h0000, 1'b1};
        vecs[9] = '{ACT_SEC,   9,  16'h0009, 1'b1};

        // Reset with pause_btn already held high.
        pause_btn = 1'b1;
        cycles(3);
        check("reset_digits", mmss(), 16'h0000);
        check("reset_running", {15'd0, running}, 16'd0);
        check("reset_adjusting", {15'd0, adjusting}, 16'd0);
        rst = 1'b1;
        cycles(10);
        check("held_level_at_reset_ignored", {15'd0, running}, 16'd0);
        pause_btn = 1'b0;
        cycles(HOLD);

        for (int i = 0; i < 10; i++) begin
            case (vecs[i].act)
                ACT_SEC:   pulse_sec(vecs[i].n);
                ACT_PAUSE: press_pause();
                default:   press_clear();
            endcase
            check($sformatf("vec%0d_digits", i), mmss(), vecs[i].exp_time);
            check($sformatf("vec%0d_running", i), {15'd0, running}, {15'd0, vecs[i].exp_run});
        end

        // Pause and sec tick in the same cycle at 00:09.
        sec_clk = 1'b1;
        pause_btn = 1'b1;
        cycles(HOLD);
        sec_clk = 1'b0;
        pause_btn = 1'b0;
        cycles(HOLD);
        check("same_cycle_digits", mmss(), 16'h0010);
        check("same_cycle_paused", {15'd0, running}, 16'd0);

        // pause_btn to running latency.
        pause_btn = 1'b1;
        cycles(SYNC_STAGES);
        check("pause_latency_early", {15'd0, running}, 16'd0);
        cycles(1);
        check("pause_latency_ontime", {15'd0, running}, 16'd1);
        cycles(HOLD);
        pause_btn = 1'b0;
        cycles(HOLD);

        // sec_clk to digit latency, then a long high level gives one tick.
        sec_clk = 1'b1;
        cycles(SYNC_STAGES);
        check("sec_latency_early", mmss(), 16'h0010);
        cycles(1);
        check("sec_latency_ontime", mmss(), 16'h0011);
        cycles(20);
        check("held_sec_one_tick", mmss(), 16'h0011);
        sec_clk = 1'b0;
        cycles(HOLD);

        // Clear at 12:34 coincident with a tick.
        pulse_sec(743);
        check("reach_1234", mmss(), 16'h1234);
        reset_btn = 1'b1;
        sec_clk = 1'b1;
        cycles(SYNC_STAGES);
        check("clear_latency_early", mmss(), 16'h1234);
        cycles(1);
        check("clear_over_tick_digits", mmss(), 16'h0000);
        check("clear_over_tick_running", {15'd0, running}, 16'd0);
        sec_clk = 1'b0;
        cycles(HOLD);
        press_pause();
        check("clear_held_ignores_pause", {15'd0, running}, 16'd0);
        reset_btn = 1'b0;
        cycles(HOLD);
        check("clear_release_idle", {15'd0, running}, 16'd0);

        // Full-range wrap 59:59 -> 00:00 stays in RUN.
        press_pause();
        pulse_sec(3599);
        check("reach_5959", mmss(), 16'h5959);
        pulse_sec(1);
        check("wrap_digits", mmss(), 16'h0000);
        check("wrap_running", {15'd0, running}, 16'd1);

        // Asynchronous rst mid-count at 03:27.
        pulse_sec(207);
        check("reach_0327", mmss(), 16'h0327);
        #2 rst = 1'b0;
        #1;
        check("async_rst_digits", mmss(), 16'h0000);
        check("async_rst_running", {15'd0, running}, 16'd0);
        cycles(2);
        rst = 1'b1;
        cycles(HOLD + 2);
        pulse_sec(2);
        check("after_rst_idle_digits", mmss(), 16'h0000);
        check("after_rst_idle_running", {15'd0, running}, 16'd0);

        // Reach PAUSE at 00:58 for the adjust-switch checks.
        press_pause();
        pulse_sec(58);
        press_pause();
        check("paused_0058", mmss(), 16'h0058);
        adj = 1'b1;
        sel = 1'b0;
        cycles(HOLD);
        for (int i = 0; i < 3; i++) begin
            adj_clk = 1'b1;
            cycles(HOLD);
            adj_clk = 1'b0;
            cycles(HOLD);
        end
`ifdef STOPWATCH_ADJUST_EN
        check("adjust_active", {15'd0, adjusting}, 16'd1);
        check("adjust_sec_wrap", mmss(), 16'h0001);
        adj = 1'b0;
        cycles(HOLD);
        check("adjust_exit", {15'd0, adjusting}, 16'd0);
        check("adjust_exit_paused", {15'd0, running}, 16'd0);
`else
        check("adjust_absent", {15'd0, adjusting}, 16'd0);
        check("adjust_ignored_digits", mmss(), 16'h0058);
        adj = 1'b0;
        cycles(HOLD);
        press_pause();
        check("adjust_ignored_resume", {15'd0, running}, 16'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Timekeeping core of the FPGA stopwatch, directly downstream of the `clocks` divider. It samples the divider's `sec_clk` output, along with the user buttons, in the master clock domain and counts elapsed time as four BCD digits (MM:SS). It presents those digits to the display multiplexer, which is driven by `display_clk`.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flop depth of each input synchronizer (legal range 2–4).
- `MAX_MIN`, default 59: largest minute value before wrap (legal range 1–99).

Ports:
- `clk` input 1: master clock; same net that feeds `clocks`.
- `rst` input 1: asynchronous, active-low reset.
- `sec_clk` input 1: 1 Hz square wave from `clocks`, asynchronous to `clk` by treatment.
- `adj_clk` input 1: 2 Hz square wave (`blink_clk` from `clocks`); used only with the adjust feature.
- `pause_btn` input 1: start/pause button, raw level.
- `reset_btn` input 1: clear button, raw level, active-high.
- `adj` input 1: adjust-mode switch, raw level.
- `sel` input 1: adjust field select; 0 = seconds, 1 = minutes.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` output 4 each: BCD digits.
- `running` output 1: high in RUN.
- `adjusting` output 1: high in ADJUST.

## Operation
- Every asynchronous input passes through a `SYNC_STAGES`-deep synchronizer.
- `sec_clk`, `adj_clk` and `pause_btn` also get a rising-edge detector (one extra flop). This yields the single-cycle pulses `sec_tick`, `adj_tick` and `pause_pe`.
- States are IDLE, RUN, PAUSE and ADJUST (ADJUST exists only with the macro).
- IDLE:
  - `pause_pe` → RUN.
  - synchronized `adj` high → ADJUST.
- RUN:
  - `sec_tick` increments the count.
  - `pause_pe` → PAUSE.
- PAUSE:
  - count holds.
  - `pause_pe` → RUN.
  - `adj` high → ADJUST.
- ADJUST:
  - `adj_tick` increments the selected field only, with no carry between fields.
  - seconds wrap 59→00; minutes wrap `MAX_MIN`→00.
  - `adj` low → PAUSE.
- Synchronized `reset_btn` high, in any state:
  - all digits go to 0 and the state goes to IDLE.
  - it overrides a same-cycle `sec_tick`, `pause_pe` or `adj_tick`.
  - while it stays high, the block remains in IDLE and ignores all other events.
- Count increment, BCD:
  - `sec_ones` 9→0 carries into `sec_tens`; `sec_tens` 5→0 carries into the minutes.
  - minutes increment as a two-digit BCD value.
  - `MAX_MIN`:59 + 1 → 00:00, and the state stays RUN.
- Digits never hold a non-BCD value (>9), or `sec_tens` >5.
- `pause_pe` in the same cycle as `sec_tick` while in RUN: the tick is applied first, then the state moves to PAUSE.
- `adj` asserted while in RUN is ignored; the user must pause first.

## Timing
- Reset values:
  - all digit outputs 4'h0.
  - `running` = 0, `adjusting` = 0, state IDLE.
  - synchronizer and edge flops cleared to 0.
- Latency, `sec_clk` rising edge at the pin to the updated digit output: `SYNC_STAGES`+1 `clk` cycles. Outputs are registered.
- Latency, `pause_btn` rising edge to `running` change: `SYNC_STAGES`+1 cycles.
- Latency, `reset_btn` high to digits at zero: `SYNC_STAGES`+1 cycles.
- A level held high produces exactly one pulse. The rising edge of a level already high when `rst` deasserts is not detected.
- `rst` asserted mid-count clears all state immediately, asynchronously. Release is synchronous to `clk` by the system.
- `running` and `adjusting` are decoded from registered state, with no glitches.

## Configuration
- Macro `STOPWATCH_ADJUST_EN`.
- Defined:
  - the ADJUST state and `adj_tick` logic are built.
  - `adj`, `sel` and `adj_clk` are live.
- Undefined:
  - ADJUST is absent.
  - the `adj`, `sel` and `adj_clk` ports remain but are unused.
  - `adjusting` is tied to 0.
  - IDLE/PAUSE ignore `adj`.

## Structure
- Package `stopwatch_pkg` holds:
  - the state enum `sw_state_t` (IDLE, RUN, PAUSE, ADJUST).
  - the BCD digit type.
  - the constants `SEC_TENS_MAX` = 5 and `BCD_MAX` = 9.
- One sub-module, `sync_edge`: a parameterized synchronizer plus rising-edge pulse, instantiated for `sec_clk`, `adj_clk` and `pause_btn`. `reset_btn` and `adj` use its synchronized level output.

## Test plan
- Reset, then press `pause_btn`, then apply 61 `sec_clk` periods → digits read 01:01 and `running` = 1.
- Preload to 59:59 via RUN, then apply one more `sec_tick` → 00:00, `running` stays 1.
- `pause_btn` and a `sec_clk` edge arrive on the same cycle at 00:09 → digits 00:10, state PAUSE.
- Assert `reset_btn` at 12:34 in RUN coincident with `sec_tick` → 00:00, IDLE, `running` = 0 after `SYNC_STAGES`+1 cycles.
- With `STOPWATCH_ADJUST_EN`: from PAUSE at 00:58, set `adj` = 1, `sel` = 0, give 3 `adj_clk` edges → 00:01, minutes unchanged, `adjusting` = 1; then `adj` = 0 → PAUSE.
- Pulse `rst` low mid-count at 03:27 → all outputs 0 within the same cycle, IDLE.
